eth_txbackoff: RTL and testbench

- Transmit-side collision, jam and backoff controller for the Ethernet MAC. It runs in the MTxClk domain, one nibble per clock.
- It drives the StateJam/StateJam_q/RetryCnt/NibCnt/ByteCnt inputs of the backoff random generator. It consumes that generator's RandomEq0/RandomEqByteCnt outputs to time the backoff.
- It then defers for the inter-packet gap and either requests a retransmission or aborts once the retry limit is reached.

---
 rtl/eth_txbackoff.sv | 136 +++++++++++++
 tb/tb_eth_txbackoff.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_txbackoff.sv
// Ethernet MAC transmit collision/jam/backoff controller: jams after a collision, waits out
// the random backoff, defers for the inter-packet gap, then retries or aborts at the retry limit.
module eth_txbackoff #(
  parameter int unsigned MAX_RETRY   = 15,
  parameter int unsigned JAM_NIBBLES = 8,
  parameter int unsigned IPG_NIBBLES = 24
) (
  input  logic        MTxClk,
  input  logic        Resetn,
  input  logic        TxStartFrm,
  input  logic        TxEndFrm,
  input  logic        Collision,
  input  logic        CarrierSense,
  input  logic        RandomEq0,
  input  logic        RandomEqByteCnt,
  output logic        StateIdle,
  output logic        StateTx,
  output logic        StateJam,
  output logic        StateJam_q,
  output logic        StateBackoff,
  output logic        StateDefer,
  output logic [3:0]  RetryCnt,
  output logic [15:0] NibCnt,
  output logic [9:0]  ByteCnt,
  output logic        TxDone,
  output logic        TxRetry,
  output logic        TxAbort
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_TX      = 5'b00010,
    S_JAM     = 5'b00100,
    S_BACKOFF = 5'b01000,
    S_DEFER   = 5'b10000
  } state_t;

  localparam logic [3:0]  MAX_RC   = 4'(MAX_RETRY);
  localparam logic [15:0] JAM_LAST = 16'(JAM_NIBBLES - 1);
  localparam logic [15:0] IPG_LAST = 16'(IPG_NIBBLES - 1);

  state_t state;
  logic   abort_flag;
  logic   first_backoff;

  assign StateIdle    = (state == S_IDLE);
  assign StateTx      = (state == S_TX);
  assign StateJam     = (state == S_JAM);
  assign StateBackoff = (state == S_BACKOFF);
  assign StateDefer   = (state == S_DEFER);

  always_ff @(posedge MTxClk or negedge Resetn) begin
    if (!Resetn) begin
      state         <= S_IDLE;
      StateJam_q    <= 1'b0;
      RetryCnt      <= '0;
      NibCnt        <= '0;
      ByteCnt       <= '0;
      abort_flag    <= 1'b0;
      first_backoff <= 1'b0;
      TxDone        <= 1'b0;
      TxRetry       <= 1'b0;
      TxAbort       <= 1'b0;
    end else begin
      TxDone     <= 1'b0;
      TxRetry    <= 1'b0;
      TxAbort    <= 1'b0;
      StateJam_q <= (state == S_JAM);
      unique case (state)
        S_IDLE: begin
          NibCnt  <= '0;
          ByteCnt <= '0;
          if (TxStartFrm) state <= S_TX;
        end
        S_TX: begin
          // Collision wins over end-of-frame in the same nibble
          if (Collision) begin
            state  <= S_JAM;
            NibCnt <= '0;
            if (RetryCnt < MAX_RC) RetryCnt <= RetryCnt + 4'd1;
            else                   abort_flag <= 1'b1;
          end else if (TxEndFrm) begin
            state    <= S_IDLE;
            NibCnt   <= '0;
            RetryCnt <= '0;
            TxDone   <= 1'b1;
          end else if (NibCnt != '1) begin
            NibCnt <= NibCnt + 16'd1;
          end
        end
        S_JAM: begin
          if (NibCnt == JAM_LAST) begin
            NibCnt  <= '0;
            ByteCnt <= '0;
            if (abort_flag) begin
              state      <= S_IDLE;
              TxAbort    <= 1'b1;
              RetryCnt   <= '0;
              abort_flag <= 1'b0;
            end else begin
              state         <= S_BACKOFF;
              first_backoff <= 1'b1;
            end
          end else begin
            NibCnt <= NibCnt + 16'd1;
          end
        end
        S_BACKOFF: begin
          first_backoff <= 1'b0;
          // A zero backoff is only honoured on the first cycle, before any slot time elapses
          if ((first_backoff && RandomEq0) || RandomEqByteCnt) begin
            state   <= S_DEFER;
            NibCnt  <= '0;
            ByteCnt <= '0;
          end else begin
            NibCnt <= {9'd0, NibCnt[6:0] + 7'd1};
            if (NibCnt[6:0] == 7'h7F) ByteCnt <= ByteCnt + 10'd1;
          end
        end
        S_DEFER: begin
          if (CarrierSense) begin
            NibCnt <= '0;
          end else if (NibCnt == IPG_LAST) begin
            state   <= S_TX;
            NibCnt  <= '0;
            TxRetry <= 1'b1;
          end else begin
            NibCnt <= NibCnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_txbackoff.sv
// Bench for eth_txbackoff: constant-checked vector table, directed corner sequences, and
// randomized traffic compared every cycle against a counter-based behavioural model.
module tb_eth_txbackoff;

  localparam int unsigned MAX_RETRY   = 15;
  localparam int unsigned JAM_NIBBLES = 8;
  localparam int unsigned IPG_NIBBLES = 24;

  logic clk = 1'b0;
  logic rst_n;
  logic TxStartFrm, TxEndFrm, Collision, CarrierSense, RandomEq0, RandomEqByteCnt;
  logic StateIdle, StateTx, StateJam, StateJam_q, StateBackoff, StateDefer;
  logic [3:0]  RetryCnt;
  logic [15:0] NibCnt;
  logic [9:0]  ByteCnt;
  logic TxDone, TxRetry, TxAbort;
  logic [38:0] dut_out;

  always #5 clk = ~clk;

  eth_txbackoff #(
    .MAX_RETRY  (MAX_RETRY),
    .JAM_NIBBLES(JAM_NIBBLES),
    .IPG_NIBBLES(IPG_NIBBLES)
  ) dut (
    .MTxClk         (clk),
    .Resetn         (rst_n),
    .TxStartFrm     (TxStartFrm),
    .TxEndFrm       (TxEndFrm),
    .Collision      (Collision),
    .CarrierSense   (CarrierSense),
    .RandomEq0      (RandomEq0),
    .RandomEqByteCnt(RandomEqByteCnt),
    .StateIdle      (StateIdle),
    .StateTx        (StateTx),
    .StateJam       (StateJam),
    .StateJam_q     (StateJam_q),
    .StateBackoff   (StateBackoff),
    .StateDefer     (StateDefer),
    .RetryCnt       (RetryCnt),
    .NibCnt         (NibCnt),
    .ByteCnt        (ByteCnt),
    .TxDone         (TxDone),
    .TxRetry        (TxRetry),
    .TxAbort        (TxAbort)
  );

  assign dut_out = {StateIdle, StateTx, StateJam, StateJam_q, StateBackoff, StateDefer,
                    RetryCnt, NibCnt, ByteCnt, TxDone, TxRetry, TxAbort};

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: phase plus elapsed-nibble counters; collisions counted without limit
  typedef enum {M_IDLE, M_TX, M_JAM, M_BACKOFF, M_DEFER} mphase_t;
  mphase_t     m_phase;
  int unsigned m_tx_n, m_jam_k, m_slot_k, m_quiet, m_ncoll;
  bit          m_jq, m_done, m_retry, m_abort;

  task automatic model_reset();
    m_phase = M_IDLE;
    m_tx_n = 0; m_jam_k = 0; m_slot_k = 0; m_quiet = 0; m_ncoll = 0;
    m_jq = 0; m_done = 0; m_retry = 0; m_abort = 0;
  endtask

  task automatic model_step(input bit start, endf, coll, cs, req0, eqb);
    mphase_t prev;
    prev = m_phase;
    m_done = 0; m_retry = 0; m_abort = 0;
    case (m_phase)
      M_IDLE: if (start) begin m_phase = M_TX; m_tx_n = 0; end
      M_TX: begin
        if (coll) begin
          m_ncoll++; m_phase = M_JAM; m_jam_k = 0;
        end else if (endf) begin
          m_done = 1; m_ncoll = 0; m_phase = M_IDLE;
        end else if (m_tx_n < 65535) m_tx_n++;
      end
      M_JAM: begin
        if (m_jam_k == JAM_NIBBLES - 1) begin
          if (m_ncoll > MAX_RETRY) begin
            m_abort = 1; m_ncoll = 0; m_phase = M_IDLE;
          end else begin
            m_phase = M_BACKOFF; m_slot_k = 0;
          end
        end else m_jam_k++;
      end
      M_BACKOFF: begin
        if ((m_slot_k == 0 && req0) || eqb) begin m_phase = M_DEFER; m_quiet = 0; end
        else m_slot_k++;
      end
      M_DEFER: begin
        if (cs) m_quiet = 0;
        else if (m_quiet == IPG_NIBBLES - 1) begin m_retry = 1; m_phase = M_TX; m_tx_n = 0; end
        else m_quiet++;
      end
      default: ;
    endcase
    m_jq = (prev == M_JAM);
  endtask

  function automatic logic [38:0] model_out();
    logic [15:0] nib;
    logic [9:0]  bc;
    logic [3:0]  rc;
    nib = '0;
    bc  = '0;
    case (m_phase)
      M_TX:      nib = 16'(m_tx_n);
      M_JAM:     nib = 16'(m_jam_k);
      M_BACKOFF: begin nib = 16'(m_slot_k % 128); bc = 10'((m_slot_k / 128) % 1024); end
      M_DEFER:   nib = 16'(m_quiet);
      default: ;
    endcase
    rc = 4'((m_ncoll > MAX_RETRY) ? MAX_RETRY : m_ncoll);
    return {m_phase == M_IDLE, m_phase == M_TX, m_phase == M_JAM, m_jq,
            m_phase == M_BACKOFF, m_phase == M_DEFER, rc, nib, bc, m_done, m_retry, m_abort};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit start, endf, coll, cs, req0, eqb);
    TxStartFrm = start; TxEndFrm = endf; Collision = coll;
    CarrierSense = cs; RandomEq0 = req0; RandomEqByteCnt = eqb;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(start, endf, coll, cs, req0, eqb);
    #1;
    check("model", 64'(dut_out), 64'(model_out()));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    TxStartFrm = 0; TxEndFrm = 0; Collision = 0; CarrierSense = 0;
    RandomEq0 = 0; RandomEqByteCnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit start, endf, coll, cs, req0, eqb;
    logic [4:0]  st;   // {idle, tx, jam, backoff, defer}
    bit          jq;
    logic [3:0]  rc;
    logic [15:0] nib;
    logic [9:0]  bc;
    logic [2:0]  pul;  // {done, retry, abort}
  } vec_t;

  function automatic vec_t mk(input bit start, endf, coll, cs, req0, eqb,
                              input logic [4:0] st, input bit jq, input logic [3:0] rc,
                              input logic [15:0] nib);
    vec_t v;
    v.start = start; v.endf = endf; v.coll = coll; v.cs = cs; v.req0 = req0; v.eqb = eqb;
    v.st = st; v.jq = jq; v.rc = rc; v.nib = nib; v.bc = '0; v.pul = '0;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   cnt;
    bit   pj, eqb;

    // Short frame, collision coinciding with end-of-frame, zero backoff, defer with ignored inputs
    tbl.push_back(mk(0,0,0,0,0,0, 5'b10000, 0, 4'd0, 16'd0));
    tbl.push_back(mk(1,0,0,0,0,0, 5'b01000, 0, 4'd0, 16'd0));
    tbl.push_back(mk(0,0,0,0,0,0, 5'b01000, 0, 4'd0, 16'd1));
    tbl.push_back(mk(0,0,0,0,0,0, 5'b01000, 0, 4'd0, 16'd2));
    tbl.push_back(mk(0,1,1,0,0,0, 5'b00100, 0, 4'd1, 16'd0));
    for (int i = 1; i < 8; i++) tbl.push_back(mk(1,1,0,0,0,0, 5'b00100, 1, 4'd1, 16'(i)));
    tbl.push_back(mk(0,0,0,0,1,0, 5'b00010, 1, 4'd1, 16'd0));
    tbl.push_back(mk(0,0,0,0,1,0, 5'b00001, 0, 4'd1, 16'd0));
    tbl.push_back(mk(0,0,0,0,0,0, 5'b00001, 0, 4'd1, 16'd1));
    tbl.push_back(mk(0,0,0,1,0,0, 5'b00001, 0, 4'd1, 16'd0));
    tbl.push_back(mk(1,1,1,0,0,0, 5'b00001, 0, 4'd1, 16'd1));
    tbl.push_back(mk(0,0,0,0,0,0, 5'b00001, 0, 4'd1, 16'd2));

    do_reset();
    check("reset_state", 64'(dut_out), 64'({1'b1, 38'd0}));
    foreach (tbl[i]) begin
      cyc(tbl[i].start, tbl[i].endf, tbl[i].coll, tbl[i].cs, tbl[i].req0, tbl[i].eqb);
      check($sformatf("tbl[%0d]", i),
            64'({StateIdle, StateTx, StateJam, StateBackoff, StateDefer, StateJam_q,
                 RetryCnt, NibCnt, ByteCnt, TxDone, TxRetry, TxAbort}),
            64'({tbl[i].st, tbl[i].jq, tbl[i].rc, tbl[i].nib, tbl[i].bc, tbl[i].pul}));
    end

    // 100-nibble frame, no collision
    do_reset();
    cyc(1,0,0,0,0,0);
    repeat (99) cyc(0,0,0,0,0,0);
    check("t1_nib99", 64'(NibCnt), 64'd99);
    cyc(0,1,0,0,0,0);
    check("t1_done", 64'({TxDone, StateIdle, RetryCnt}), 64'({1'b1, 1'b1, 4'd0}));
    cyc(0,0,0,0,0,0);
    check("t1_done_width", 64'(TxDone), 64'd0);

    // Collision at nibble 20, zero backoff, full inter-packet gap
    cyc(1,0,0,0,0,0);
    repeat (20) cyc(0,0,0,0,0,0);
    check("t2_nib20", 64'(NibCnt), 64'd20);
    cyc(0,0,1,0,0,0);
    cnt = 1;
    for (int k = 0; k < 20 && StateJam; k++) begin
      pj = StateJam;
      cyc(0,0,0,0,1,0);
      check("t2_jam_q_lag", 64'(StateJam_q), 64'(pj));
      if (StateJam) cnt++;
    end
    check("t2_jam_len", 64'(cnt), 64'(JAM_NIBBLES));
    check("t2_retrycnt", 64'(RetryCnt), 64'd1);
    check("t2_in_backoff", 64'(StateBackoff), 64'd1);
    cyc(0,0,0,0,1,0);
    check("t2_zero_backoff", 64'(StateDefer), 64'd1);
    cnt = 1;
    for (int k = 0; k < 100 && StateDefer; k++) begin
      cyc(0,0,0,0,0,0);
      if (StateDefer) cnt++;
    end
    check("t2_defer_len", 64'(cnt), 64'(IPG_NIBBLES));
    check("t2_retry", 64'({TxRetry, StateTx}), 64'(2'b11));

    // Second collision, backoff of four slots
    cyc(0,0,1,0,0,0);
    repeat (JAM_NIBBLES) cyc(0,0,0,0,0,0);
    check("t3_in_backoff", 64'(StateBackoff), 64'd1);
    cnt = 1;
    for (int k = 0; k < 2000 && StateBackoff; k++) begin
      eqb = (ByteCnt == 10'd3 && NibCnt[6:0] == 7'h7F);
      cyc(0,0,0,0,0,eqb);
      if (StateBackoff) cnt++;
    end
    check("t3_backoff_len", 64'(cnt), 64'd512);
    check("t3_retrycnt", 64'({StateDefer, RetryCnt}), 64'({1'b1, 4'd2}));

    // Carrier sense restarts the inter-packet gap
    repeat (10) cyc(0,0,0,0,0,0);
    check("t4_nib10", 64'(NibCnt), 64'd10);
    cyc(0,0,0,1,0,0);
    check("t4_cs_clear", 64'({StateDefer, NibCnt}), 64'({1'b1, 16'd0}));
    cnt = 1;
    for (int k = 0; k < 100 && StateDefer; k++) begin
      cyc(0,0,0,0,0,0);
      if (StateDefer) cnt++;
    end
    check("t4_defer_len", 64'(cnt), 64'(IPG_NIBBLES));
    check("t4_retry", 64'({TxRetry, StateTx}), 64'(2'b11));

    // Retry limit: 16 collisions on one frame
    do_reset();
    cyc(1,0,0,0,0,0);
    for (int i = 1; i <= 16; i++) begin
      cyc(0,0,1,0,0,0);
      check($sformatf("t5_rc_%0d", i), 64'(RetryCnt), 64'((i > 15) ? 15 : i));
      repeat (JAM_NIBBLES - 1) cyc(0,0,0,0,0,0);
      cyc(0,0,0,0,1,0);
      if (i < 16) begin
        cyc(0,0,0,0,1,0);
        repeat (IPG_NIBBLES) cyc(0,0,0,0,0,0);
        check($sformatf("t5_retry_%0d", i), 64'({StateTx, TxRetry}), 64'(2'b11));
      end else begin
        check("t5_abort", 64'({StateIdle, TxAbort, TxRetry, RetryCnt}),
              64'({1'b1, 1'b1, 1'b0, 4'd0}));
        cyc(0,0,0,0,0,0);
        check("t5_abort_width", 64'(TxAbort), 64'd0);
      end
    end

    // Collision together with end-of-frame, then reset in the middle of backoff
    do_reset();
    cyc(1,0,0,0,0,0);
    repeat (3) cyc(0,0,0,0,0,0);
    cyc(0,1,1,0,0,0);
    check("t6_coll_prio", 64'({StateJam, TxDone}), 64'(2'b10));
    repeat (JAM_NIBBLES) cyc(0,0,0,0,0,0);
    repeat (50) cyc(0,0,0,0,0,0);
    check("t6_backoff_nib", 64'({StateBackoff, NibCnt}), 64'({1'b1, 16'd50}));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_reset", 64'(dut_out), 64'({1'b1, 38'd0}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rand_async_reset", 64'(dut_out), 64'(model_out()));
        cyc(0,0,0,0,0,0);
        rst_n = 1'b1;
      end
      cyc(($urandom % 4) == 0, ($urandom % 40) == 0, ($urandom % 40) == 0,
          ($urandom % 16) == 0, ($urandom % 2) == 0, ($urandom % 64) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
